cmp_share_arbiter: RTL and testbench

- Shares one 64-bit magnitude comparator (EQ, signed LT, unsigned LT) among NREQ requesters.
- Round-robin arbitration selects one request per cycle.
- Two-stage pipeline: operand register, then result register. One response channel returns results tagged with the requester ID, under valid/ready backpressure.
- Sits between the integer-unit/branch clients and the comparator-tree datapath.

---
 rtl/cmp_share_arbiter_if.sv | 31 +++
 rtl/cmp_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_share_arbiter_if.sv
// Request/response bus of the shared comparator.
//   req_valid/req_ready/req_a/req_b/req_signed : per-requester request channel
//   rsp_valid/rsp_ready/rsp_id/rsp_eq/rsp_lt/rsp_ltu : single tagged response channel
// master: requester/consumer side; slave: the arbiter.
interface cmp_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_signed;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_eq;
    logic                  rsp_lt;
    logic                  rsp_ltu;

    modport master (
        output req_valid, req_a, req_b, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu
    );

    modport slave (
        input  req_valid, req_a, req_b, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Shares one WIDTH-bit comparator (EQ, signed LT, unsigned LT) among NREQ
// requesters. Round-robin grant, two-stage pipeline (operands, results),
// one tagged response channel with valid/ready backpressure.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : cmp_share_arbiter_if.slave (request and response channels)
//   grant_cnt: NREQ x 16-bit saturating accept counters   (CMP_SHARE_ARBITER_STATS_EN)
//   stall_cnt: 16-bit saturating response-stall counter   (CMP_SHARE_ARBITER_STATS_EN)
// IDW must equal clog2(NREQ).
module cmp_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned IDW   = 2,
    localparam int unsigned CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cmp_share_arbiter_if.slave   bus
`ifdef CMP_SHARE_ARBITER_STATS_EN
    ,
    output logic [NREQ*CNTW-1:0] grant_cnt,
    output logic [CNTW-1:0]      stall_cnt
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sgn;
        logic [IDW-1:0]   id;
    } s1_t;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [NREQ-1:0] grant;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic            adv1;
    logic            adv2;

    logic            s1_valid;
    s1_t             s1;
    s1_t             s1_nxt;

    logic            s2_valid;
    logic [IDW-1:0]  s2_id;
    logic            s2_eq;
    logic            s2_lt;
    logic            s2_ltu;

    logic            eq_c;
    logic            ltu_c;
    logic            lts_c;

    // Pipeline advance conditions
    assign adv2 = !s2_valid || bus.rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // Round-robin search starting at ptr; no grant while in reset or stalled
    always_comb begin
        int unsigned j;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        j       = 0;
        if (reset_n && adv1) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                j = 32'(ptr) + k;
                if (j >= NREQ) begin
                    j = j - NREQ;
                end
                if (!gnt_any && bus.req_valid[IDW'(j)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDW'(j);
                end
            end
            if (gnt_any) begin
                grant[gnt_idx] = 1'b1;
            end
        end
    end

    assign bus.req_ready = grant;

    assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

    // Mux of the granted requester's operands into the stage-1 payload
    always_comb begin
        s1_nxt     = '0;
        s1_nxt.a   = bus.req_a[32'(gnt_idx) * WIDTH +: WIDTH];
        s1_nxt.b   = bus.req_b[32'(gnt_idx) * WIDTH +: WIDTH];
        s1_nxt.sgn = bus.req_signed[gnt_idx];
        s1_nxt.id  = gnt_idx;
    end

    // Comparator; signed LT reuses the unsigned compare with both MSBs flipped
    assign eq_c  = (s1.a == s1.b);
    assign ltu_c = (s1.a < s1.b);
    assign lts_c = ({~s1.a[WIDTH-1], s1.a[WIDTH-2:0]} < {~s1.b[WIDTH-1], s1.b[WIDTH-2:0]});

    // Pointer and both pipeline stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1       <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_eq    <= 1'b0;
            s2_lt    <= 1'b0;
            s2_ltu   <= 1'b0;
        end else begin
            if (gnt_any) begin
                ptr <= ptr_nxt;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_id  <= s1.id;
                    s2_eq  <= eq_c;
                    s2_lt  <= s1.sgn ? lts_c : ltu_c;
                    s2_ltu <= ltu_c;
                end
            end
            if (adv1) begin
                s1_valid <= gnt_any;
                if (gnt_any) begin
                    s1 <= s1_nxt;
                end
            end
        end
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_id    = s2_id;
    assign bus.rsp_eq    = s2_eq;
    assign bus.rsp_lt    = s2_lt;
    assign bus.rsp_ltu   = s2_ltu;

`ifdef CMP_SHARE_ARBITER_STATS_EN
    logic [CNTW-1:0] scnt;

    // Per-requester saturating accept counters
    for (genvar i = 0; i < NREQ; i++) begin : g_gcnt
        logic [CNTW-1:0] gcnt;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                gcnt <= '0;
            end else if (grant[i] && (gcnt != '1)) begin
                gcnt <= gcnt + CNTW'(1);
            end
        end
        assign grant_cnt[i*CNTW +: CNTW] = gcnt;
    end

    // Saturating count of cycles where a result waits on the consumer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt <= '0;
        end else if (s2_valid && !bus.rsp_ready && (scnt != '1)) begin
            scnt <= scnt + CNTW'(1);
        end
    end

    assign stall_cnt = scnt;
`endif

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed vector table, directed
// rotation/backpressure/reset sequences, then randomized traffic against a
// transaction-level model (2-entry in-order buffer, round-robin pick).
module tb_cmp_share_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned IDW   = 2;

    logic clk;
    logic reset_n;

    cmp_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

`ifdef CMP_SHARE_ARBITER_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
    logic [15:0]        stall_cnt;
`endif

    cmp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus)
`ifdef CMP_SHARE_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] a;
        logic [63:0] b;
        logic        sgn;
        logic        eq;
        logic        lt;
        logic        ltu;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic       eq;
        logic       lt;
        logic       ltu;
        int         acc;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          mptr  = 0;
    int          m_stall = 0;
    int          m_gcnt [NREQ];
    exp_t        q [$];
    logic [3:0]  pend;
    logic [63:0] pa [NREQ];
    logic [63:0] pb [NREQ];
    logic [3:0]  ps;
    logic        rsp_rdy;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        bus.req_valid  = pend;
        bus.req_a      = {pa[3], pa[2], pa[1], pa[0]};
        bus.req_b      = {pb[3], pb[2], pb[1], pb[0]};
        bus.req_signed = ps;
        bus.rsp_ready  = rsp_rdy;
    endtask

    task automatic model_clear();
        q.delete();
        mptr    = 0;
        m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
    endtask

    // One clock of model-checked operation; entered and left just after a rising edge
    task automatic tick(output int g);
        logic       vis;
        logic       pop;
        logic [3:0] exp_rdy;
        exp_t       e;
        drive_inputs();
        #1;
        vis = 1'b0;
        if (q.size() > 0) vis = ((cyc - q[0].acc) >= 2);
        check("rsp_valid", 64'(bus.rsp_valid), 64'(vis));
        if (vis) begin
            check("rsp_id_eq_lt_ltu", 64'({bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_ltu}),
                  64'({q[0].id, q[0].eq, q[0].lt, q[0].ltu}));
        end
        pop = vis && rsp_rdy;
        g = -1;
        if ((q.size() - int'(pop)) < 2) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (mptr + k) % NREQ;
                if (g < 0 && pend[j]) g = j;
            end
        end
        exp_rdy = (g < 0) ? 4'b0000 : (4'(1) << g);
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if (vis && !rsp_rdy) m_stall++;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (g >= 0) begin
            e.id  = 2'(g);
            e.eq  = (pa[g] == pb[g]);
            e.ltu = (pa[g] < pb[g]);
            e.lt  = ps[g] ? ($signed(pa[g]) < $signed(pb[g])) : e.ltu;
            e.acc = cyc;
            q.push_back(e);
            pend[g] = 1'b0;
            mptr    = (g + 1) % NREQ;
            m_gcnt[g]++;
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input string name);
        int g;
        int n;
        n = 0;
        rsp_rdy = 1'b1;
        while ((q.size() > 0 || pend != 4'b0000) && n < 60) begin
            tick(g);
            n++;
        end
        tests++;
        if (q.size() > 0 || pend != 4'b0000) begin
            fails++;
            $display("FAIL %s_drain: outstanding %0d/%b expected 0/0000", name, q.size(), pend);
        end
    endtask

    // Single isolated request with explicit latency and result checks
    task automatic run_vec(input int n, input vec_t v);
        pend        = 4'b0000;
        pend[v.id]  = 1'b1;
        pa[v.id]    = v.a;
        pb[v.id]    = v.b;
        ps[v.id]    = v.sgn;
        rsp_rdy     = 1'b1;
        drive_inputs();
        #1;
        check($sformatf("vec%0d_ready", n), 64'(bus.req_ready), 64'(4'(1) << v.id));
        @(posedge clk);
        #1;
        cyc++;
        pend = 4'b0000;
        mptr = (int'(v.id) + 1) % NREQ;
        m_gcnt[v.id]++;
        drive_inputs();
        #1;
        check($sformatf("vec%0d_valid_n1", n), 64'(bus.rsp_valid), 64'(0));
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("vec%0d_valid_n2", n), 64'(bus.rsp_valid), 64'(1));
        check($sformatf("vec%0d_result", n), 64'({bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_ltu}),
              64'({v.id, v.eq, v.lt, v.ltu}));
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("vec%0d_drained", n), 64'(bus.rsp_valid), 64'(0));
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rnd_b(input logic [63:0] a);
        logic [63:0] one;
        one = 64'h1;
        case ($urandom_range(0, 3))
            0:       return a;
            1:       return a ^ (one << $urandom_range(0, 63));
            2:       return {~a[63], a[62:0]};
            default: return rnd64();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int n;
        logic [63:0] big;

        vecs[0] = '{2'd0, 64'd5,                  64'd7,                  1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'd1, 64'h1234,               64'h1234,               1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'd0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{2'd3, 64'd9,                  64'd3,                  1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < NREQ; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        ps      = 4'b0000;
        rsp_rdy = 1'b1;
        model_clear();

        // Reset state, with every requester asking
        reset_n = 1'b0;
        pend    = 4'b1111;
        drive_inputs();
        #3;
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("reset_rsp_fields", 64'({bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_ltu}), 64'(0));
        check("reset_req_ready", 64'(bus.req_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready_held", 64'(bus.req_ready), 64'(0));
        pend = 4'b0000;
        drive_inputs();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // All requesters valid continuously: grants rotate 0,1,2,3,0
        big = 64'h8000_0000_0000_0000;
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = big;
            pb[i] = big;
        end
        ps      = 4'b0101;
        pend    = 4'b1111;
        rsp_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_inputs();
            #1;
            check($sformatf("rotate_grant%0d", k), 64'(bus.req_ready), 64'(4'(1) << (k % NREQ)));
            tick(g);
            if (g >= 0 && k < 4) pend[g] = 1'b1;
        end
        drain("rotate");

        // Backpressure: three requesters, consumer stalls 5 cycles
        for (int i = 1; i < NREQ; i++) begin
            pa[i] = rnd64();
            pb[i] = rnd_b(pa[i]);
        end
        ps      = 4'b1010;
        pend    = 4'b1110;
        rsp_rdy = 1'b0;
        repeat (5) tick(g);
        drain("stall");

        // Reset while both stages are full
        for (int i = 0; i < 3; i++) begin
            pa[i] = rnd64();
            pb[i] = rnd_b(pa[i]);
        end
        pend    = 4'b0111;
        rsp_rdy = 1'b0;
        n = 0;
        while (q.size() < 2 && n < 10) begin
            tick(g);
            n++;
        end
        reset_n = 1'b0;
        #1;
        check("midreset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("midreset_req_ready", 64'(bus.req_ready), 64'(0));
        model_clear();
        @(posedge clk);
        #1;
        cyc++;
        check("midreset_rsp_valid_held", 64'(bus.rsp_valid), 64'(0));
        pend[0] = 1'b1;
        pend[2] = 1'b1;
        rsp_rdy = 1'b1;
        drive_inputs();
        reset_n = 1'b1;
        #1;
        check("postreset_first_grant", 64'(bus.req_ready), 64'(4'b0001));
        drain("postreset");

        // Randomized traffic with random consumer backpressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pa[i]   = rnd64();
                    pb[i]   = rnd_b(pa[i]);
                    ps[i]   = 1'($urandom_range(0, 1));
                end
            end
            rsp_rdy = ($urandom_range(0, 9) < 7);
            tick(g);
        end
        drain("random");

`ifdef CMP_SHARE_ARBITER_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            check($sformatf("grant_cnt%0d", i), 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
        end
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
